// File: rtl/simple_fixed_point_unsigned_long_multiplication_pkg.sv
// ============================================================================
//  Module      : fxp_arith_pkg
//  Description : Shared fixed-point arithmetic types and width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fxp_arith_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } mul_state_t;

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    // One extra bit so the step counter can reach WIDTH without wrapping
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/simple_fixed_point_unsigned_long_multiplication_if.sv
// ============================================================================
//  Module      : simple_fixed_point_unsigned_long_multiplication_if
//  Description : start/busy/done/valid/ovf handshake and operand/result bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simple_fixed_point_unsigned_long_multiplication_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic             o_busy;
    logic             o_done;
    logic             o_valid;
    logic             o_ovf;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] o_val;

    modport master (
        output i_start, a, b,
        input  o_busy, o_done, o_valid, o_ovf, o_val
    );

    modport slave (
        input  i_start, a, b,
        output o_busy, o_done, o_valid, o_ovf, o_val
    );
endinterface

`default_nettype wire

// File: rtl/simple_fixed_point_unsigned_long_multiplication_round_sat.sv
// ============================================================================
//  Module      : fxp_round_sat
//  Description : Extracts the Q-format result from the full product and flags
//                overflow. Macro ROUND_NEAREST_EN selects round-half-up.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_round_sat
    import fxp_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FBITS = 4
) (
    input  wire logic [prod_w(WIDTH)-1:0] i_prod,
    output logic      [WIDTH-1:0]         o_val,
    output logic                          o_ovf
);
    logic [WIDTH-1:0] w_trunc;
    logic [WIDTH-1:0] w_rounded;
    logic             w_carry;
    logic             w_hi_nz;
    logic             w_unused_lsbs;

    assign w_trunc       = i_prod[WIDTH+FBITS-1:FBITS];
    assign w_hi_nz       = |i_prod[prod_w(WIDTH)-1:WIDTH+FBITS];
    assign w_unused_lsbs = ^i_prod;

`ifdef ROUND_NEAREST_EN
    generate
        if (FBITS > 0) begin : g_round
            logic [WIDTH:0] w_rsum;
            assign w_rsum    = {1'b0, w_trunc} + {{WIDTH{1'b0}}, i_prod[FBITS-1]};
            assign w_rounded = w_rsum[WIDTH-1:0];
            assign w_carry   = w_rsum[WIDTH];
        end else begin : g_no_frac
            assign w_rounded = w_trunc;
            assign w_carry   = 1'b0;
        end
    endgenerate
`else
    assign w_rounded = w_trunc;
    assign w_carry   = 1'b0;
`endif

    assign o_ovf = w_hi_nz | w_carry;
    assign o_val = o_ovf ? '0 : w_rounded;

endmodule

`default_nettype wire

// File: rtl/simple_fixed_point_unsigned_long_multiplication.sv
// ============================================================================
//  Module      : simple_fixed_point_unsigned_long_multiplication
//  Description : Iterative shift-and-add unsigned Q-format multiplier, one
//                multiplier bit per clock. Optional macro: ROUND_NEAREST_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_fixed_point_unsigned_long_multiplication
    import fxp_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FBITS = 4
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    simple_fixed_point_unsigned_long_multiplication_if.slave bus
);
    localparam int                 c_PROD_W   = prod_w(WIDTH);
    localparam int                 c_CNT_W    = cnt_w(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);

    mul_state_t          r_state;
    mul_state_t          w_next_state;
    logic                w_load;
    logic                w_step;
    logic                w_finish;

    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mplr;
    logic [WIDTH-1:0]    r_acc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_done;
    logic                r_valid;
    logic                r_ovf;
    logic [WIDTH-1:0]    r_val;

    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_acc_nxt;
    logic [WIDTH-1:0]    w_mplr_nxt;
    logic [c_PROD_W-1:0] w_prod;
    logic [WIDTH-1:0]    w_rs_val;
    logic                w_rs_ovf;

    // One shift-and-add step; on the last step w_prod is the exact product
    assign w_sum      = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt  = w_sum[WIDTH:1];
    assign w_mplr_nxt = {w_sum[0], r_mplr[WIDTH-1:1]};
    assign w_prod     = {w_acc_nxt, w_mplr_nxt};

    fxp_round_sat #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_round_sat (
        .i_prod (w_prod),
        .o_val  (w_rs_val),
        .o_ovf  (w_rs_ovf)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A start while busy simply reloads the operands and restarts the count
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_load       = 1'b1;
                    w_next_state = MUL;
                end
            end
            MUL: begin
                if (bus.i_start) begin
                    w_load = 1'b1;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == c_LAST_CNT) begin
                        w_finish     = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_val   <= '0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_mcand <= bus.a;
                r_mplr  <= bus.b;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_valid <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_step) begin
                r_acc  <= w_acc_nxt;
                r_mplr <= w_mplr_nxt;
                r_cnt  <= r_cnt + 1'b1;
                if (w_finish) begin
                    r_val   <= w_rs_val;
                    r_ovf   <= w_rs_ovf;
                    r_valid <= ~w_rs_ovf;
                end
            end
        end
    end

    assign bus.o_busy  = (r_state == MUL);
    assign bus.o_done  = r_done;
    assign bus.o_valid = r_valid;
    assign bus.o_ovf   = r_ovf;
    assign bus.o_val   = r_val;

endmodule

`default_nettype wire
